clock_mode_ctrl: RTL

//  Mode/set controller for the MM:SS clock on DE1. Owns a RUN/SET_MIN/SET_SEC FSM.

---
 rtl/clock_mode_ctrl_if.sv | 29 ++
 rtl/clock_mode_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : clock_mode_ctrl_if
//  Purpose  : Key/tick inputs and counter-control outputs of clock_mode_ctrl.
//  Revision : 1.0
// ============================================================================
interface clock_mode_ctrl_if;
    logic       en1hz;
    logic       key_mode;
    logic       key_up;
    logic       key_clr;
    logic       cnt_en;
    logic       sec_up;
    logic       min_up;
    logic       clr;
    logic [3:0] blank;
    logic [1:0] mode;

    modport master (
        output en1hz, key_mode, key_up, key_clr,
        input  cnt_en, sec_up, min_up, clr, blank, mode
    );

    modport slave (
        input  en1hz, key_mode, key_up, key_clr,
        output cnt_en, sec_up, min_up, clr, blank, mode
    );
endinterface
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_mode_ctrl
//  Purpose  : RUN/SET_MIN/SET_SEC controller for the MM:SS clock: key pulses,
//             auto-repeat, idle timeout and set-field blink mask.
//  Revision : 1.0
// ============================================================================
module clock_mode_ctrl #(
    parameter int unsigned BLINK_HALF = 12_500_000,
    parameter int unsigned REPEAT_DLY = 25_000_000,
    parameter int unsigned REPEAT_PER = 5_000_000,
    parameter int unsigned TIMEOUT    = 500_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    clock_mode_ctrl_if.slave  bus_io
);

    localparam int unsigned c_bw   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned c_rmax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned c_rw   = (c_rmax > 1) ? $clog2(c_rmax) : 1;
    localparam int unsigned c_tw   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_bw-1:0] c_blink_last = c_bw'(BLINK_HALF - 1);
    localparam logic [c_rw-1:0] c_dly_last   = c_rw'(REPEAT_DLY - 1);
    localparam logic [c_rw-1:0] c_per_last   = c_rw'(REPEAT_PER - 1);
    localparam logic [c_tw-1:0] c_to_last    = c_tw'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_SEC = 2'd2
    } mode_e;

    mode_e             mode_q, mode_d;
    logic              key_mode_q, key_up_q, key_clr_q;
    logic              clr_q, clr_d;
    logic              min_up_q, min_up_d;
    logic              sec_up_q, sec_up_d;
    logic [3:0]        blank_q, blank_d;
    logic              phase_q, phase_d;
    logic [c_bw-1:0]   blink_cnt_q, blink_cnt_d;
    logic              rep_arm_q, rep_arm_d;
    logic              rep_first_q, rep_first_d;
    logic [c_rw-1:0]   rep_cnt_q, rep_cnt_d;
    logic [c_tw-1:0]   idle_q, idle_d;

    logic w_mode_rise, w_up_rise, w_clr_rise;
    logic w_any_key, w_in_set, w_rep_due, w_timeout;
    logic w_step, w_mode_chg;

    always_comb begin
        w_mode_rise = bus_io.key_mode & ~key_mode_q;
        w_up_rise   = bus_io.key_up   & ~key_up_q;
        w_clr_rise  = bus_io.key_clr  & ~key_clr_q;
        w_any_key   = bus_io.key_mode | bus_io.key_up | bus_io.key_clr;
        w_in_set    = (mode_q != RUN);
        w_rep_due   = rep_arm_q & bus_io.key_up &
                      (rep_first_q ? (rep_cnt_q == c_dly_last) : (rep_cnt_q == c_per_last));
        w_timeout   = (TIMEOUT != 0) & w_in_set & ~w_any_key & (idle_q == c_to_last);

        mode_d      = mode_q;
        clr_d       = 1'b0;
        min_up_d    = 1'b0;
        sec_up_d    = 1'b0;
        w_step      = 1'b0;
        w_mode_chg  = 1'b0;
        rep_arm_d   = rep_arm_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;

        if (!bus_io.key_up || !w_in_set) begin
            rep_arm_d = 1'b0;
            rep_cnt_d = '0;
        end else if (rep_arm_q) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end

        // clr beats a mode change, which beats an up/repeat step
        if (w_clr_rise) begin
            clr_d = 1'b1;
            if (w_rep_due) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end
        end else if (w_mode_rise || w_timeout) begin
            w_mode_chg = 1'b1;
            rep_arm_d  = 1'b0;
            rep_cnt_d  = '0;
            if (w_timeout) begin
                mode_d = RUN;
            end else begin
                case (mode_q)
                    RUN:     mode_d = SET_MIN;
                    SET_MIN: mode_d = SET_SEC;
                    default: mode_d = RUN;
                endcase
            end
        end else if (w_up_rise && w_in_set) begin
            w_step      = 1'b1;
            rep_arm_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
        end else if (w_rep_due) begin
            w_step      = 1'b1;
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
        end

        if (w_step) begin
            min_up_d = (mode_q == SET_MIN);
            sec_up_d = (mode_q == SET_SEC);
        end

        // digits stay solid while a held key is stepping the field
        if (w_mode_chg || w_step || (rep_arm_q && bus_io.key_up)) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
        end

        if ((TIMEOUT == 0) || w_any_key || w_mode_chg || (mode_d == RUN)) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end

        blank_d = 4'b0000;
        if (phase_d) begin
            case (mode_d)
                SET_MIN: blank_d = 4'b1100;
                SET_SEC: blank_d = 4'b0011;
                default: blank_d = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= RUN;
            key_mode_q  <= 1'b1;
            key_up_q    <= 1'b1;
            key_clr_q   <= 1'b1;
            clr_q       <= 1'b0;
            min_up_q    <= 1'b0;
            sec_up_q    <= 1'b0;
            blank_q     <= 4'b0000;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
            rep_arm_q   <= 1'b0;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= '0;
            idle_q      <= '0;
        end else begin
            mode_q      <= mode_d;
            key_mode_q  <= bus_io.key_mode;
            key_up_q    <= bus_io.key_up;
            key_clr_q   <= bus_io.key_clr;
            clr_q       <= clr_d;
            min_up_q    <= min_up_d;
            sec_up_q    <= sec_up_d;
            blank_q     <= blank_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
            rep_arm_q   <= rep_arm_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
            idle_q      <= idle_d;
        end
    end

    assign bus_io.cnt_en = bus_io.en1hz & (mode_q == RUN);
    assign bus_io.sec_up = sec_up_q;
    assign bus_io.min_up = min_up_q;
    assign bus_io.clr    = clr_q;
    assign bus_io.blank  = blank_q;
    assign bus_io.mode   = mode_q;

endmodule
`default_nettype wire
